// File: rtl/piso_stream_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | piso_stream_serializer: handshake-loaded PISO with one-word hold buffer   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module piso_stream_serializer #(
  parameter int DATA_W    = 128,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ser_en,
  input  logic              abort,
  output logic [LANES-1:0]  serial_out,
  output logic              ser_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int BEATS = DATA_W / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if (DATA_W % LANES != 0) begin : g_width_check
      $fatal(1, "piso_stream_serializer: DATA_W must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic                beat;
  logic                last_beat;
  logic [DATA_W-1:0]   shreg_adv;
  logic [LANES-1:0]    lane_grp;

  // Output end of the shifter and the zero-filled advance toward it
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign lane_grp  = shreg_q[DATA_W-1 -: LANES];
      assign shreg_adv = shreg_q << LANES;
    end else begin : g_lsb_first
      assign lane_grp  = shreg_q[LANES-1:0];
      assign shreg_adv = shreg_q >> LANES;
    end
  endgenerate

  assign load_ready = ~hold_full_q;
  assign accept     = load_valid & ~hold_full_q;
  assign ser_valid  = (state_q == ST_SHIFT);
  assign beat       = ser_valid & ser_en;
  assign last_beat  = beat & (cnt_q == LAST_CNT);
  assign word_done  = last_beat & ~abort;
  assign busy       = ser_valid | hold_full_q;
  assign serial_out = ser_valid ? lane_grp : '0;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;

    if (abort) begin
      state_d     = ST_IDLE;
      shreg_d     = '0;
      hold_d      = '0;
      hold_full_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shreg_d = data_in;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last_beat) begin
            // Refill from hold first, then from a same-cycle accept, for zero-gap streaming
            cnt_d = '0;
            if (hold_full_q) begin
              shreg_d     = hold_q;
              hold_full_d = 1'b0;
            end else if (accept) begin
              shreg_d = data_in;
            end else begin
              shreg_d = shreg_adv;
              state_d = ST_IDLE;
            end
          end else begin
            if (beat) begin
              shreg_d = shreg_adv;
              cnt_d   = cnt_q + CNT_W'(1);
            end
            if (accept) begin
              hold_d      = data_in;
              hold_full_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_stream_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_piso_stream_serializer: bench for piso_stream_serializer               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_piso_stream_serializer;

  localparam int DW = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          load_valid, ser_en, abort;
  logic [DW-1:0] data_in;
  logic          load_ready, ser_valid, word_done, busy;
  logic [0:0]    serial_out;

  logic          s_lv, s_en, s_ab;
  logic [15:0]   s_din;
  logic          l_rdy, l_val, l_done, l_busy;
  logic [3:0]    l_out;
  logic          m_rdy, m_val, m_done, m_busy;
  logic [3:0]    m_out;

  piso_stream_serializer #(.DATA_W(DW), .LANES(1), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .ser_en(ser_en), .abort(abort), .serial_out(serial_out),
    .ser_valid(ser_valid), .word_done(word_done), .busy(busy));

  piso_stream_serializer #(.DATA_W(16), .LANES(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .load_valid(s_lv), .load_ready(l_rdy),
    .data_in(s_din), .ser_en(s_en), .abort(s_ab), .serial_out(l_out),
    .ser_valid(l_val), .word_done(l_done), .busy(l_busy));

  piso_stream_serializer #(.DATA_W(16), .LANES(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .load_valid(s_lv), .load_ready(m_rdy),
    .data_in(s_din), .ser_en(s_en), .abort(s_ab), .serial_out(m_out),
    .ser_valid(m_val), .word_done(m_done), .busy(m_busy));

  int n_vec = 0;
  int n_err = 0;

  // Reference: queue of accepted words not yet fully emitted, plus bit index into the head
  logic [DW-1:0] mq[$];
  int            midx;
  logic          e_valid, e_out, e_done, e_ready, e_busy;

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_clear();
    mq.delete();
    midx = 0;
  endtask

  // Drive one cycle, compute expected outputs for it, then advance the reference
  task automatic tick(input logic lv, input logic [DW-1:0] d, input logic en, input logic ab);
    logic [DW-1:0] head;
    @(negedge clk);
    load_valid = lv; data_in = d; ser_en = en; abort = ab;
    #1;
    e_valid = (mq.size() > 0);
    e_ready = (mq.size() < 2);
    e_busy  = e_valid;
    head    = e_valid ? mq[0] : '0;
    e_out   = e_valid ? head[DW-1-midx] : 1'b0;
    e_done  = e_valid && en && !ab && (midx == DW-1);
    if (ab) begin
      model_clear();
    end else begin
      if (e_valid && en) begin
        if (midx == DW-1) begin
          mq.delete(0);
          midx = 0;
        end else begin
          midx++;
        end
      end
      if (lv && e_ready) mq.push_back(d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; load_valid = 1'b0; ser_en = 1'b0; abort = 1'b0; data_in = '0;
    s_lv = 1'b0; s_en = 1'b0; s_ab = 1'b0; s_din = '0;
    model_clear();
    #3;
    n_vec++;
    if ({ser_valid, serial_out, word_done, busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000", {ser_valid, serial_out, word_done, busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_vec++;
    if ({load_ready, busy, ser_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: got %b want 100", {load_ready, busy, ser_valid});
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    int nvalid = 0, ndone = 0, done_at = -1;
    logic prev_done = 1'b0;
    w = {1'b1, {(DW-2){1'b0}}, 1'b1};
    tick(1'b1, w, 1'b1, 1'b0);
    for (int c = 0; c < 140; c++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      n_vec++;
      if ({ser_valid, serial_out, word_done, load_ready, busy} !== {e_valid, e_out, e_done, e_ready, e_busy}) begin
        n_err++;
        $display("FAIL single c=%0d: got %b want %b", c,
                 {ser_valid, serial_out, word_done, load_ready, busy}, {e_valid, e_out, e_done, e_ready, e_busy});
      end
      if (prev_done) begin
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after_done: got %b want 0", busy); end
      end
      if (ser_valid === 1'b1) nvalid++;
      if (word_done === 1'b1) begin ndone++; done_at = nvalid; end
      prev_done = (word_done === 1'b1);
    end
    n_vec++;
    if (nvalid != 128 || ndone != 1 || done_at != 128) begin
      n_err++;
      $display("FAIL single_counts: got valid=%0d done=%0d at=%0d want 128/1/128", nvalid, ndone, done_at);
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0, first_v = -1, last_v = -1, nlow = 0;
    int d0 = -1, d1 = -1;
    tick(1'b1, rand_word(), 1'b1, 1'b0);
    tick(1'b1, rand_word(), 1'b1, 1'b0);
    for (int c = 0; c < 270; c++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      n_vec++;
      if ({ser_valid, serial_out, word_done, load_ready, busy} !== {e_valid, e_out, e_done, e_ready, e_busy}) begin
        n_err++;
        $display("FAIL b2b c=%0d: got %b want %b", c,
                 {ser_valid, serial_out, word_done, load_ready, busy}, {e_valid, e_out, e_done, e_ready, e_busy});
      end
      if (ser_valid === 1'b1) begin
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (load_ready === 1'b0) nlow++;
      if (word_done === 1'b1) begin
        if (d0 < 0) d0 = c; else d1 = c;
      end
    end
    // The word loaded in the first cycle already emitted beat 0 in the second
    n_vec++;
    if (nvalid != 255 || last_v - first_v + 1 != 255) begin
      n_err++;
      $display("FAIL b2b_contig: got valid=%0d span=%0d want 255/255", nvalid, last_v - first_v + 1);
    end
    n_vec++;
    if (d1 - d0 != 128 || nlow != 127) begin
      n_err++;
      $display("FAIL b2b_done_ready: got gap=%0d ready_low=%0d want 128/127", d1 - d0, nlow);
    end
  endtask

  task automatic test_stall();
    int nvalid = 0, done_at = -1, stalls = 0;
    logic en;
    logic frozen;
    frozen = 1'b0;
    tick(1'b1, rand_word(), 1'b1, 1'b0);
    for (int c = 0; c < 160; c++) begin
      en = !(mq.size() > 0 && midx == 40 && stalls < 5);
      tick(1'b0, '0, en, 1'b0);
      n_vec++;
      if ({ser_valid, serial_out, word_done, load_ready, busy} !== {e_valid, e_out, e_done, e_ready, e_busy}) begin
        n_err++;
        $display("FAIL stall c=%0d: got %b want %b", c,
                 {ser_valid, serial_out, word_done, load_ready, busy}, {e_valid, e_out, e_done, e_ready, e_busy});
      end
      if (!en) begin
        if (stalls == 0) frozen = serial_out[0];
        n_vec++;
        if (serial_out[0] !== frozen) begin
          n_err++;
          $display("FAIL stall_frozen: got %b want %b", serial_out[0], frozen);
        end
        stalls++;
      end
      if (ser_valid === 1'b1) nvalid++;
      if (word_done === 1'b1) done_at = nvalid;
    end
    n_vec++;
    if (nvalid != 133 || done_at != 133) begin
      n_err++;
      $display("FAIL stall_counts: got valid=%0d done_at=%0d want 133/133", nvalid, done_at);
    end
  endtask

  task automatic test_lanes();
    logic [15:0] w, t;
    logic [3:0]  exp_l, exp_m;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 16'h1234 : 16'($urandom);
      @(negedge clk);
      s_lv = 1'b1; s_din = w; s_en = 1'b1;
      @(negedge clk);
      s_lv = 1'b0;
      for (int i = 0; i < 4; i++) begin
        #1;
        t = w >> (4 * i);        exp_l = t[3:0];
        t = w >> (12 - 4 * i);   exp_m = t[3:0];
        n_vec++;
        if ({l_val, l_out, l_done} !== {1'b1, exp_l, (i == 3)}) begin
          n_err++;
          $display("FAIL lanes_lsb w=%h beat=%0d: got v=%b o=%h d=%b want o=%h", w, i, l_val, l_out, l_done, exp_l);
        end
        n_vec++;
        if ({m_val, m_out, m_done} !== {1'b1, exp_m, (i == 3)}) begin
          n_err++;
          $display("FAIL lanes_msb w=%h beat=%0d: got v=%b o=%h d=%b want o=%h", w, i, m_val, m_out, m_done, exp_m);
        end
        if (i < 3) @(negedge clk);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({l_val, l_out, l_busy, m_val, m_out, m_busy} !== 12'h000) begin
        n_err++;
        $display("FAIL lanes_idle: got lsb v=%b o=%h b=%b msb v=%b o=%h b=%b want all 0",
                 l_val, l_out, l_busy, m_val, m_out, m_busy);
      end
    end
    s_en = 1'b0;
  endtask

  task automatic test_abort();
    int guard = 0;
    int bad = 0;
    tick(1'b1, rand_word(), 1'b1, 1'b0);
    tick(1'b1, rand_word(), 1'b1, 1'b0);
    while (midx != 60 && guard < 200) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    n_vec++;
    if (guard >= 200 || mq.size() != 2) begin
      n_err++;
      $display("FAIL abort_setup: got guard=%0d queued=%0d want <200/2", guard, mq.size());
    end
    tick(1'b1, rand_word(), 1'b1, 1'b1);
    n_vec++;
    if ({ser_valid, word_done, load_ready, busy} !== 4'b1001) begin
      n_err++;
      $display("FAIL abort_cycle: got %b want 1001", {ser_valid, word_done, load_ready, busy});
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_vec++;
    if ({ser_valid, serial_out, busy, load_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL abort_after: got %b want 0001", {ser_valid, serial_out, busy, load_ready});
    end
    for (int c = 0; c < 150; c++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      if (ser_valid !== 1'b0 || word_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int nvalid = 0;
    tick(1'b1, rand_word(), 1'b1, 1'b0);
    tick(1'b1, rand_word(), 1'b1, 1'b0);
    for (int c = 0; c < 30; c++) tick(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if ({ser_valid, serial_out, word_done, busy, load_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL async_reset: got %b want 00001", {ser_valid, serial_out, word_done, busy, load_ready});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick(1'b1, rand_word(), 1'b1, 1'b0);
    for (int c = 0; c < 135; c++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      n_vec++;
      if ({ser_valid, serial_out, word_done, load_ready, busy} !== {e_valid, e_out, e_done, e_ready, e_busy}) begin
        n_err++;
        $display("FAIL post_reset c=%0d: got %b want %b", c,
                 {ser_valid, serial_out, word_done, load_ready, busy}, {e_valid, e_out, e_done, e_ready, e_busy});
      end
      if (ser_valid === 1'b1) nvalid++;
    end
    n_vec++;
    if (nvalid != 128) begin
      n_err++;
      $display("FAIL post_reset_count: got %0d want 128", nvalid);
    end
  endtask

  task automatic test_random();
    logic lv, en, ab;
    for (int c = 0; c < 1500; c++) begin
      lv = ($urandom_range(0, 1) == 1);
      en = ($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 99) == 0);
      tick(lv, rand_word(), en, ab);
      n_vec++;
      if ({ser_valid, serial_out, word_done, load_ready, busy} !== {e_valid, e_out, e_done, e_ready, e_busy}) begin
        n_err++;
        $display("FAIL random c=%0d: got %b want %b", c,
                 {ser_valid, serial_out, word_done, load_ready, busy}, {e_valid, e_out, e_done, e_ready, e_busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lanes();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
